// File: rtl/pipe_exe_mdu_if.sv
// Start/busy/done handshake and operand/result bundle for the execute-stage MDU.
// master drives start/op/a/b/flush; slave returns busy/done/hi/lo/div0.
interface pipe_exe_mdu_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             div0;

    modport master (
        output start, op, a, b, flush,
        input  busy, done, hi, lo, div0
    );

    modport slave (
        input  start, op, a, b, flush,
        output busy, done, hi, lo, div0
    );
endinterface

// File: rtl/pipe_exe_mdu.sv
// Multi-cycle multiply/divide unit: pipelined multiplier and restoring divider.
// Ports: clk, rst (sync, active-high), mdu (slave modport: start/op/a/b/flush in,
// busy/done/hi/lo/div0 out). Optional macro MDU_DIV0_EXC_EN: early div-by-zero exit.
module pipe_exe_mdu #(
    parameter int WIDTH      = 32,
    parameter int MUL_STAGES = 2
) (
    input logic            clk,
    input logic            rst,
    pipe_exe_mdu_if.slave  mdu
);
    localparam int W  = WIDTH;
    localparam int CW = $clog2(WIDTH + 2);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_MUL  = CW'(MUL_STAGES);
    localparam logic [CW-1:0] CNT_ITER = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_FIX  = CW'(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            done_q, done_d;
    logic            div0_q, div0_d;
    logic [W-1:0]    hi_q, hi_d;
    logic [W-1:0]    lo_q, lo_d;

    logic [W-1:0]    a_q;
    logic [W-1:0]    dvs_q;
    logic [W-1:0]    quo_q;
    logic [W-1:0]    rem_q;
    logic            negq_q;
    logic            negr_q;
    logic            dz_q;
    logic [2*W-1:0]  mp_q [MUL_STAGES];

    logic            accept;
    logic            is_div;
    logic            a_neg, b_neg, b_zero;
    logic [W-1:0]    a_mag, b_mag;
    logic [2*W-1:0]  ext_a, ext_b, prod_in;
    logic [W:0]      shifted, diff;
    logic [W-1:0]    q_fix, r_fix;

    // Accept only when idle; done implies idle, giving back-to-back issue.
    assign accept = mdu.start && !mdu.flush && (state_q == S_IDLE);
    assign is_div = mdu.op[1];
    assign a_neg  = !mdu.op[0] && mdu.a[W-1];
    assign b_neg  = !mdu.op[0] && mdu.b[W-1];
    assign b_zero = (mdu.b == '0);
    assign a_mag  = a_neg ? -mdu.a : mdu.a;
    assign b_mag  = b_neg ? -mdu.b : mdu.b;

    // Sign-extended 2W product; low 2W bits are exact for both signednesses.
    assign ext_a   = {{W{a_neg}}, mdu.a};
    assign ext_b   = {{W{b_neg}}, mdu.b};
    assign prod_in = ext_a * ext_b;

    // One restoring step: partial remainder never exceeds 2*divisor.
    assign shifted = {rem_q, quo_q[W-1]};
    assign diff    = shifted - {1'b0, dvs_q};

    assign q_fix = dz_q ? '1  : (negq_q ? -quo_q : quo_q);
    assign r_fix = dz_q ? a_q : (negr_q ? -rem_q : rem_q);

    always_ff @(posedge clk) begin
        if (accept) begin
            a_q     <= mdu.a;
            dvs_q   <= b_mag;
            quo_q   <= a_mag;
            rem_q   <= '0;
            negq_q  <= a_neg ^ b_neg;
            negr_q  <= a_neg;
            dz_q    <= b_zero;
            mp_q[0] <= prod_in;
        end else if (state_q == S_DIV && cnt_q <= CNT_ITER) begin
            if (!diff[W]) begin
                rem_q <= diff[W-1:0];
                quo_q <= {quo_q[W-2:0], 1'b1};
            end else begin
                rem_q <= shifted[W-1:0];
                quo_q <= {quo_q[W-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 1; i < MUL_STAGES; i++) begin
            mp_q[i] <= mp_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            div0_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            div0_q  <= div0_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        div0_d  = 1'b0;
        hi_d    = hi_q;
        lo_d    = lo_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    cnt_d   = CNT_ONE;
                    state_d = is_div ? S_DIV : S_MUL;
`ifdef MDU_DIV0_EXC_EN
                    // Skip iteration: complete on the very next edge.
                    if (is_div && b_zero) begin
                        cnt_d = CNT_FIX;
                    end
`endif
                end
            end
            S_MUL: begin
                if (cnt_q == CNT_MUL) begin
                    state_d      = S_IDLE;
                    done_d       = 1'b1;
                    {hi_d, lo_d} = mp_q[MUL_STAGES-1];
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_DIV: begin
                if (cnt_q == CNT_FIX) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    hi_d    = r_fix;
                    lo_d    = q_fix;
`ifdef MDU_DIV0_EXC_EN
                    div0_d  = dz_q;
`endif
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Squash: drop everything in flight, keep the last result.
        if (mdu.flush) begin
            state_d = S_IDLE;
            done_d  = 1'b0;
            div0_d  = 1'b0;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end
    end

    assign mdu.busy = (state_q != S_IDLE);
    assign mdu.done = done_q;
    assign mdu.div0 = div0_q;
    assign mdu.hi   = hi_q;
    assign mdu.lo   = lo_q;
endmodule

// File: tb/tb_pipe_exe_mdu.sv
// Table-driven bench for pipe_exe_mdu (WIDTH=32, MUL_STAGES=2).
// Adapts divide-by-zero expectations to MDU_DIV0_EXC_EN.
module tb_pipe_exe_mdu;
    localparam int W = 32;
`ifdef MDU_DIV0_EXC_EN
    localparam int   DZ_LAT = 1;
    localparam logic DZ_FLG = 1'b1;
`else
    localparam int   DZ_LAT = 33;
    localparam logic DZ_FLG = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipe_exe_mdu_if #(.WIDTH(W)) bus ();

    pipe_exe_mdu #(
        .WIDTH(W),
        .MUL_STAGES(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .mdu(bus)
    );

    typedef struct {
        string       nm;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          lat;
    } vec_t;

    vec_t vt[12];
    int   nvec = 0;
    int   nerr = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b);
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = -1;
        for (int i = 1; i <= 100; i++) begin
            tick();
            if (bus.done === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    int lat;
    int ndone;

    initial begin
        vt[0]  = '{"mult_m2x3",   2'b00, 32'hFFFFFFFE, 32'h3,
                   32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0, 2};
        vt[1]  = '{"multu_max",   2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF,
                   32'hFFFFFFFE, 32'h00000001, 1'b0, 2};
        vt[2]  = '{"mult_minsq",  2'b00, 32'h80000000, 32'h80000000,
                   32'h40000000, 32'h00000000, 1'b0, 2};
        vt[3]  = '{"mult_m1m1",   2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF,
                   32'h00000000, 32'h00000001, 1'b0, 2};
        vt[4]  = '{"multu_5x6",   2'b01, 32'd5, 32'd6,
                   32'h0, 32'd30, 1'b0, 2};
        vt[5]  = '{"div_m7_2",    2'b10, 32'hFFFFFFF9, 32'h2,
                   32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33};
        vt[6]  = '{"divu_m7_2",   2'b11, 32'hFFFFFFF9, 32'h2,
                   32'h00000001, 32'h7FFFFFFC, 1'b0, 33};
        vt[7]  = '{"div_ovf",     2'b10, 32'h80000000, 32'hFFFFFFFF,
                   32'h00000000, 32'h80000000, 1'b0, 33};
        vt[8]  = '{"div_7_m2",    2'b10, 32'h7, 32'hFFFFFFFE,
                   32'h00000001, 32'hFFFFFFFD, 1'b0, 33};
        vt[9]  = '{"divu_by0",    2'b11, 32'h1234, 32'h0,
                   32'h00001234, 32'hFFFFFFFF, DZ_FLG, DZ_LAT};
        vt[10] = '{"div_neg_by0", 2'b10, 32'hFFFFFFF0, 32'h0,
                   32'hFFFFFFF0, 32'hFFFFFFFF, DZ_FLG, DZ_LAT};
        vt[11] = '{"div_100_7",   2'b10, 32'd100, 32'd7,
                   32'd2, 32'd14, 1'b0, 33};

        bus.start = 1'b0;
        bus.flush = 1'b0;
        bus.op    = 2'b00;
        bus.a     = '0;
        bus.b     = '0;
        rst       = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_div0", 64'(bus.div0), 64'd0);
        chk("rst_hi",   64'(bus.hi),   64'd0);
        chk("rst_lo",   64'(bus.lo),   64'd0);

        for (int i = 0; i < 12; i++) begin
            issue(vt[i].op, vt[i].a, vt[i].b);
            chk({vt[i].nm, "_busy"}, 64'(bus.busy), 64'd1);
            wait_done(lat);
            chk({vt[i].nm, "_lat"},  64'(lat),         64'(vt[i].lat));
            chk({vt[i].nm, "_hi"},   64'(bus.hi),      64'(vt[i].hi));
            chk({vt[i].nm, "_lo"},   64'(bus.lo),      64'(vt[i].lo));
            chk({vt[i].nm, "_div0"}, 64'(bus.div0),    64'(vt[i].dz));
            chk({vt[i].nm, "_dbusy"}, 64'(bus.busy),   64'd0);
            tick();
            chk({vt[i].nm, "_pulse"}, 64'(bus.done),   64'd0);
        end

        // Flush mid-divide: no done, result registers keep 100/7.
        issue(2'b10, 32'hFFFFFF00, 32'd3);
        for (int i = 0; i < 9; i++) tick();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        chk("flush_busy", 64'(bus.busy), 64'd0);
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.done === 1'b1) ndone++;
        end
        chk("flush_nodone", 64'(ndone), 64'd0);
        chk("flush_hi", 64'(bus.hi), 64'd2);
        chk("flush_lo", 64'(bus.lo), 64'd14);

        // Flush and start together: start is dropped.
        bus.flush = 1'b1;
        issue(2'b01, 32'd3, 32'd3);
        bus.flush = 1'b0;
        chk("fls_start_busy", 64'(bus.busy), 64'd0);
        ndone = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.done === 1'b1) ndone++;
        end
        chk("fls_start_nodone", 64'(ndone), 64'd0);

        // Reset mid-divide clears every output.
        issue(2'b10, 32'd1000, 32'd9);
        for (int i = 0; i < 4; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_busy", 64'(bus.busy), 64'd0);
        chk("midrst_done", 64'(bus.done), 64'd0);
        chk("midrst_div0", 64'(bus.div0), 64'd0);
        chk("midrst_hi",   64'(bus.hi),   64'd0);
        chk("midrst_lo",   64'(bus.lo),   64'd0);

        // Back-to-back multiplies with an ignored start while busy.
        issue(2'b01, 32'd5, 32'd6);
        wait_done(lat);
        chk("b2b1_lat", 64'(lat),    64'd2);
        chk("b2b1_lo",  64'(bus.lo), 64'd30);
        issue(2'b01, 32'd7, 32'd8);
        chk("b2b2_busy", 64'(bus.busy), 64'd1);
        chk("b2b2_done", 64'(bus.done), 64'd0);
        issue(2'b01, 32'd9, 32'd9);
        chk("ign_early", 64'(bus.done), 64'd0);
        tick();
        chk("b2b2_at2", 64'(bus.done), 64'd1);
        chk("b2b2_lo",  64'(bus.lo),   64'd56);
        chk("b2b2_hi",  64'(bus.hi),   64'd0);
        ndone = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.done === 1'b1) ndone++;
        end
        chk("ign_nodone", 64'(ndone),    64'd0);
        chk("ign_busy",   64'(bus.busy), 64'd0);
        chk("ign_lo",     64'(bus.lo),   64'd56);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/pipe_exe_mdu.md
# pipe_exe_mdu

Parametrised multi-cycle multiply/divide unit for the execute stage of the pipeline CPU. It replaces single-cycle combinational multiply/divide with a pipelined multiplier and an iterative restoring divider behind a start/busy/done handshake. The pipeline control stalls on `busy`. On `done`, `hi`/`lo` carry the result for the HI/LO write-back path.

## Interface
- `WIDTH`, 32: operand width in bits; must be even and at least 8.
- `MUL_STAGES`, 2: multiplier latency in cycles, from start acceptance to `done`; range 1..4.
- `clk` input 1: clock; all state updates on the rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `start` input 1: request a new operation; accepted only when the unit is in IDLE or when `done`=1 in the same cycle.
- `op` input 2: 00 = MULT (signed), 01 = MULTU, 10 = DIV (signed), 11 = DIVU.
- `a` input WIDTH: rs operand (multiplicand / dividend).
- `b` input WIDTH: rt operand (multiplier / divisor).
- `flush` input 1: abort the in-flight operation (branch/exception squash).
- `busy` output 1: an operation is in flight and the result is not yet available.
- `done` output 1: one-cycle pulse; `hi`/`lo` are valid in this cycle.
- `hi` output WIDTH: product upper half, or remainder for divide.
- `lo` output WIDTH: product lower half, or quotient for divide.
- `div0` output 1: divide-by-zero flag, valid with `done` (only under the `MDU_DIV0_EXC_EN` configuration).

## Operation
- **States:**
  - IDLE.
  - MUL: counter runs from 1 to MUL_STAGES.
  - DIV: counter runs from 1 to WIDTH+1.
- **Accept (cycle 0):**
  - Operands and `op` are latched.
  - For signed ops, the absolute values and the result signs are captured.
  - `op[1]` selects the MUL or DIV state.
- **MUL:**
  - Computes the full 2·WIDTH product of the latched operands.
  - Signed or unsigned according to `op[0]`.
  - The internal register chain is MUL_STAGES deep.
- **DIV:**
  - Cycles 1..WIDTH each perform one restoring shift-subtract on the magnitudes, MSB first.
  - Cycle WIDTH+1 applies sign fix-up:
    - quotient is negated if the operand signs differ;
    - remainder takes the sign of the dividend;
    - quotient truncates toward zero.
- **Divide edge cases:**
  - Most-negative ÷ −1 (signed): q = most-negative, r = 0. No flag.
  - Divide by zero: q = all ones, r = a, for both signed and unsigned.
- **Result registers:** `hi`/`lo` hold the last completed result until the next `done`. They are not cleared on new `start` or on `flush`.
- **`start` while busy:** ignored. No queueing, and the in-flight operation is unaffected.
- **`flush`:**
  - Return to IDLE at the next edge.
  - No `done` for the aborted op; `hi`/`lo` are unchanged.
  - If `flush` and `start` coincide, `flush` wins and `start` is dropped.
- **`rst`:** at the next edge → IDLE, with `busy`=0, `done`=0, `div0`=0, `hi`=0, `lo`=0. This applies even mid-operation.

## Timing
- Start is accepted at edge 0.
- `busy`:
  - =1 from edge 0 until the edge at which `done` rises, exclusive.
  - =0 in the `done` cycle.
- `done` latency:
  - MUL: `done`=1 in the cycle after edge MUL_STAGES.
  - DIV: `done`=1 in the cycle after edge WIDTH+1.
  - MULTU with MUL_STAGES=2: `done` goes high 2 cycles after `start`.
  - DIVU with WIDTH=32: `done` goes high 33 cycles after `start`.
- **Back-to-back:** `start` in the `done` cycle is accepted. `busy` is then 1 in the next cycle, giving zero bubble cycles.
- **Steady state:** `hi`/`lo` change only on the edge that raises `done`, or on reset.

## Configuration
- **`MDU_DIV0_EXC_EN` defined:**
  - A divisor of 0 is detected at accept.
  - The unit skips iteration and raises `done` one cycle after `start`, with `div0`=1, q = all ones, r = a.
  - `div0` is 0 for every other completion.
- **`MDU_DIV0_EXC_EN` not defined:**
  - Divide by zero runs the full WIDTH+1 cycles with the same q/r values.
  - `div0` is tied to 0.

## Test plan
- **Reset and MULT:** `rst` for 2 cycles, then MULT with a=0xFFFFFFFE (−2), b=3 → after 2 cycles, `done`=1, hi=0xFFFFFFFF, lo=0xFFFFFFFA; `busy`=1 in the cycle between.
- **Signed DIV:** a=−7 (0xFFFFFFF9), b=2 → after 33 cycles, lo=0xFFFFFFFD (−3), hi=0xFFFFFFFF (−1). A repeat with DIVU on the same operands gives lo=0x7FFFFFFC, hi=1.
- **Overflow case:** DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0, `div0`=0.
- **Divide by zero:** DIVU a=0x1234, b=0.
  - With `MDU_DIV0_EXC_EN`: `done`+`div0` after 1 cycle.
  - Without it: `done` after 33 cycles, `div0`=0.
  - Both: lo=0xFFFFFFFF, hi=0x1234.
- **Flush and reset mid-op:** start DIV, assert `flush` at cycle 10 → no `done` ever arrives and `hi`/`lo` keep their prior values. Then start DIV and assert `rst` at cycle 5 → all outputs are 0 the next cycle.
- **Back-to-back and ignored start:**
  - MULTU 5×6 is followed, in its `done` cycle, by MULTU 7×8.
  - Expect `done` pulses exactly 2 cycles apart, with lo=30 then lo=56.
  - A `start` asserted while `busy` is ignored.
